w3_update_module: RTL and testbench
===================================

Name: w3_update_module

Overview:
- Output-layer weight update stage, directly downstream of the layer-3 delta-weight generator.
- Collects per-weight deltaw3 values in Q6.10, then on an update command subtracts each from its stored layer-3 weight with saturation.
- Every TGT_PERIOD updates, copies the online weights into the DQN target-network weight bank.
- Both banks are exposed flat to the forward-pass datapath.

Parameters:
N_W, 4, number of layer-3 weights; index width IW = clog2(N_W), minimum 1
TGT_PERIOD, 8, completed updates between target-bank copies; legal range 1..255
INIT_W, 16'sh0400, reset value of every online and target weight (1.0 in Q6.10)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
step  in  4  training step; 0 means no training
controller  in  4  sequencer phase; value 10 is the update command
in_valid  in  1  deltaw3/in_idx valid this cycle
in_idx  in  IW  weight index for deltaw3
deltaw3  in  16  signed Q6.10 delta weight
ready  out  1  high in IDLE only
w3_flat  out  16*N_W  online weights; weight k at bits [16k+15:16k]
w3t_flat  out  16*N_W  target weights, same packing
done  out  1  one-cycle pulse at end of update
sat_flag  out  1  sticky: some update saturated
drop_err  out  1  sticky: in_valid seen while not ready
upd_cnt  out  8  completed updates since last target copy

Behaviour:
- Reset (rst=0, async): state IDLE; all online and target weights = INIT_W; pending bits, pending values, idx, upd_cnt, done, sat_flag and drop_err = 0. Reset mid-APPLY or mid-SYNC aborts; no partial write survives.
- States: IDLE, APPLY, SYNC, DONE.
- IDLE:
  - ready=1.
  - in_valid=1 → pend_val[in_idx] <= deltaw3 and pend[in_idx] <= 1. A second write to the same index overwrites the earlier one.
  - in_idx >= N_W → write ignored and drop_err set.
  - controller==10 and step!=0 → APPLY, idx <= 0. controller==10 with step==0 is ignored.
  - A capture and the start command in the same cycle: the capture is taken and is applied in this update.
- APPLY, one weight per cycle, idx 0..N_W-1:
  - If pend[idx]=1: diff = w[idx] - pend_val[idx] at 17-bit signed width. Clamp to 16'sh7FFF if diff > 32767, or to 16'sh8000 if diff < -32768; on clamp set sat_flag. Write result to w[idx] and clear pend[idx].
  - If pend[idx]=0: w[idx] unchanged.
  - At idx = N_W-1: if upd_cnt+1 == TGT_PERIOD → SYNC with idx <= 0; otherwise upd_cnt <= upd_cnt+1 and go to DONE.
- SYNC, one weight per cycle: wt[idx] <= w[idx]. At idx = N_W-1, upd_cnt <= 0 and go to DONE.
- DONE: done=1 for exactly this cycle, then IDLE.
- Latency from the start-command edge to done high: N_W+1 cycles without sync, 2*N_W+1 cycles with sync.
- in_valid while not in IDLE: data discarded, drop_err set.
- Sticky flags clear only on reset.
- Weight writes are registered; w3_flat reflects a write the cycle after the APPLY edge that produced it.
- w3_flat and w3t_flat are driven directly from registers, with no combinational path from inputs.
- TGT_PERIOD=1 means every update syncs.

Test Plan:
Config N_W=4, TGT_PERIOD=2, INIT_W=0x0400 unless noted.
- Reset: drive rst=0 mid-run → w3_flat = w3t_flat = {4{0x0400}}, ready=1, done, sat_flag, drop_err and upd_cnt all 0.
- Basic update: deltaw3 = 0x0080 to idx0 and 0xFF80 to idx2, then controller=10 with step=1 → after N_W+1 cycles done pulses once. w0 = 0x0380, w2 = 0x0480, w1 and w3 remain 0x0400, w3t unchanged, upd_cnt=1.
- Target sync: second update with deltaw3 = 0x0100 to idx1 → w1 = 0x0300; SYNC runs and done arrives 2*N_W+1 cycles after the command. w3t_flat equals w3_flat and upd_cnt=0.
- Saturation: with INIT_W=0x7F00, deltaw3 = 0x8000 to idx3 → w3 = 0x7FFF and sat_flag=1. With INIT_W=0x8100, deltaw3 = 0x7FFF to idx0 → w0 = 0x8000.
- Gating and drops:
  - controller=10 with step=0 → stays IDLE, no done.
  - in_valid during APPLY → drop_err=1 and weights unaffected.
  - in_idx=5 (with IW=3, N_W=5 variant excluded) → drop_err=1.
- Boundary: capture to idx0 in the same cycle as the start command → delta applied. Two captures to idx2 (0x0010, then 0x0020) → only 0x0020 subtracted. Reset asserted at APPLY idx=1 → all weights return to INIT_W.

Source files
------------

// File: rtl/w3_update_module.sv
// Layer-3 weight update stage: captures per-weight deltas, subtracts them from the
// online weights with saturation, and periodically copies online weights into the target bank.
module w3_update_module #(
    parameter int                 N_W        = 4,
    parameter int                 TGT_PERIOD = 8,
    parameter logic signed [15:0] INIT_W     = 16'sh0400,
    localparam int                IW         = (N_W > 1) ? $clog2(N_W) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          step,
    input  logic [3:0]          controller,
    input  logic                in_valid,
    input  logic [IW-1:0]       in_idx,
    input  logic signed [15:0]  deltaw3,
    output logic                ready,
    output logic [16*N_W-1:0]   w3_flat,
    output logic [16*N_W-1:0]   w3t_flat,
    output logic                done,
    output logic                sat_flag,
    output logic                drop_err,
    output logic [7:0]          upd_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        SYNC  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(N_W - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1'b1);
    localparam logic [8:0]    TGT_CNT  = 9'(TGT_PERIOD);

    // Returns {clamped, result} of a - b evaluated at 17-bit signed width.
    function automatic logic [16:0] sat_sub(input logic signed [15:0] a,
                                            input logic signed [15:0] b);
        logic signed [16:0] diff;
        diff = {a[15], a} - {b[15], b};
        if (diff > 17'sd32767) begin
            sat_sub = {1'b1, 16'h7FFF};
        end else if (diff < -17'sd32768) begin
            sat_sub = {1'b1, 16'h8000};
        end else begin
            sat_sub = {1'b0, diff[15:0]};
        end
    endfunction

    state_t                    state_r;
    logic [IW-1:0]             idx_r;
    logic signed [15:0]        w_r        [N_W];
    logic signed [15:0]        wt_r       [N_W];
    logic signed [15:0]        pend_val_r [N_W];
    logic [N_W-1:0]            pend_r;
    logic [7:0]                upd_cnt_r;
    logic                      ready_r;
    logic                      done_r;
    logic                      sat_flag_r;
    logic                      drop_err_r;

    logic [16:0]               sub_res_s;
    logic [8:0]                cnt_next_s;
    logic                      in_range_s;
    logic                      start_s;

    assign sub_res_s  = sat_sub(w_r[idx_r], pend_val_r[idx_r]);
    assign cnt_next_s = {1'b0, upd_cnt_r} + 9'd1;
    assign in_range_s = (32'(in_idx) < 32'(N_W));
    assign start_s    = (controller == 4'd10) && (step != 4'd0);

    // Sequencer: capture in IDLE, one weight per cycle in APPLY and SYNC, one-cycle DONE pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            idx_r      <= {IW{1'b0}};
            pend_r     <= {N_W{1'b0}};
            upd_cnt_r  <= 8'd0;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
            sat_flag_r <= 1'b0;
            drop_err_r <= 1'b0;
            for (int k = 0; k < N_W; k++) begin
                w_r[k]        <= INIT_W;
                wt_r[k]       <= INIT_W;
                pend_val_r[k] <= 16'sh0000;
            end
        end else begin
            done_r <= 1'b0;
            if (in_valid && (state_r != IDLE)) begin
                drop_err_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        if (in_range_s) begin
                            pend_val_r[in_idx] <= deltaw3;
                            pend_r[in_idx]     <= 1'b1;
                        end else begin
                            drop_err_r <= 1'b1;
                        end
                    end
                    if (start_s) begin
                        state_r <= APPLY;
                        idx_r   <= {IW{1'b0}};
                        ready_r <= 1'b0;
                    end
                end
                APPLY: begin
                    if (pend_r[idx_r]) begin
                        w_r[idx_r]    <= sub_res_s[15:0];
                        pend_r[idx_r] <= 1'b0;
                        if (sub_res_s[16]) begin
                            sat_flag_r <= 1'b1;
                        end
                    end
                    if (idx_r == LAST_IDX) begin
                        idx_r <= {IW{1'b0}};
                        // Counter holds its value through SYNC and clears when the copy completes.
                        if (cnt_next_s == TGT_CNT) begin
                            state_r <= SYNC;
                        end else begin
                            upd_cnt_r <= cnt_next_s[7:0];
                            state_r   <= DONE;
                            done_r    <= 1'b1;
                        end
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                SYNC: begin
                    wt_r[idx_r] <= w_r[idx_r];
                    if (idx_r == LAST_IDX) begin
                        idx_r     <= {IW{1'b0}};
                        upd_cnt_r <= 8'd0;
                        state_r   <= DONE;
                        done_r    <= 1'b1;
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= {IW{1'b0}};
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    for (genvar k = 0; k < N_W; k++) begin : g_flat
        assign w3_flat[16*k +: 16]  = w_r[k];
        assign w3t_flat[16*k +: 16] = wt_r[k];
    end

    assign ready    = ready_r;
    assign done     = done_r;
    assign sat_flag = sat_flag_r;
    assign drop_err = drop_err_r;
    assign upd_cnt  = upd_cnt_r;

endmodule

// File: tb/tb_w3_update_module.sv
// Bench for w3_update_module: three instances with different initial weights share one
// stimulus stream; a transaction-level model predicts every output each cycle.
module tb_w3_update_module;

    localparam int NW  = 4;
    localparam int TGT = 2;
    localparam int NI  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  step = 4'd0;
    logic [3:0]  controller = 4'd0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_idx = 2'd0;
    logic [15:0] deltaw3 = 16'h0000;

    logic [63:0] wf  [NI];
    logic [63:0] wtf [NI];
    logic        rdy [NI];
    logic        dn  [NI];
    logic        sat [NI];
    logic        drp [NI];
    logic [7:0]  uc  [NI];

    int n_checks = 0;
    int n_errors = 0;

    initial forever #5 clk = ~clk;

    w3_update_module #(.N_W(NW), .TGT_PERIOD(TGT), .INIT_W(16'sh0400)) u_main (
        .clk(clk), .rst(rst), .step(step), .controller(controller), .in_valid(in_valid),
        .in_idx(in_idx), .deltaw3(deltaw3), .ready(rdy[0]), .w3_flat(wf[0]), .w3t_flat(wtf[0]),
        .done(dn[0]), .sat_flag(sat[0]), .drop_err(drp[0]), .upd_cnt(uc[0]));

    w3_update_module #(.N_W(NW), .TGT_PERIOD(TGT), .INIT_W(16'sh7F00)) u_hi (
        .clk(clk), .rst(rst), .step(step), .controller(controller), .in_valid(in_valid),
        .in_idx(in_idx), .deltaw3(deltaw3), .ready(rdy[1]), .w3_flat(wf[1]), .w3t_flat(wtf[1]),
        .done(dn[1]), .sat_flag(sat[1]), .drop_err(drp[1]), .upd_cnt(uc[1]));

    w3_update_module #(.N_W(NW), .TGT_PERIOD(TGT), .INIT_W(16'sh8100)) u_lo (
        .clk(clk), .rst(rst), .step(step), .controller(controller), .in_valid(in_valid),
        .in_idx(in_idx), .deltaw3(deltaw3), .ready(rdy[2]), .w3_flat(wf[2]), .w3t_flat(wtf[2]),
        .done(dn[2]), .sat_flag(sat[2]), .drop_err(drp[2]), .upd_cnt(uc[2]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] init_of(input int i);
        if (i == 0) return 16'h0400;
        if (i == 1) return 16'h7F00;
        return 16'h8100;
    endfunction

    function automatic logic [15:0] sub_clamp(input logic [15:0] a, input logic [15:0] b,
                                              output bit s);
        int d;
        d = int'($signed(a)) - int'($signed(b));
        s = 1'b0;
        if (d > 32767) begin d = 32767; s = 1'b1; end
        else if (d < -32768) begin d = -32768; s = 1'b1; end
        return d[15:0];
    endfunction

    // Reference model: an update is a job of fixed length; weight k changes on job edge k+1.
    logic [15:0] m_w  [NI][NW];
    logic [15:0] m_wt [NI][NW];
    logic [15:0] m_pv [NW];
    bit          m_pend [NW];
    bit          m_sat [NI];
    bit          m_drop, m_done, m_busy, m_sync;
    int          m_cnt, m_t;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                for (int k = 0; k < NW; k++) begin
                    m_w[i][k]  = init_of(i);
                    m_wt[i][k] = init_of(i);
                end
                m_sat[i] = 1'b0;
            end
            for (int k = 0; k < NW; k++) begin m_pend[k] = 1'b0; m_pv[k] = 16'h0; end
            m_drop = 1'b0; m_done = 1'b0; m_busy = 1'b0; m_sync = 1'b0; m_cnt = 0; m_t = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (in_valid) begin
                    if (int'(in_idx) < NW) begin m_pend[in_idx] = 1'b1; m_pv[in_idx] = deltaw3; end
                    else m_drop = 1'b1;
                end
                if (controller == 4'd10 && step != 4'd0) begin
                    m_busy = 1'b1; m_t = 0; m_sync = (m_cnt + 1 == TGT);
                end
            end else begin
                int len;
                if (in_valid) m_drop = 1'b1;
                m_t++;
                len = m_sync ? 2*NW + 1 : NW + 1;
                if (m_t <= NW) begin
                    if (m_pend[m_t-1]) begin
                        for (int i = 0; i < NI; i++) begin
                            bit s;
                            m_w[i][m_t-1] = sub_clamp(m_w[i][m_t-1], m_pv[m_t-1], s);
                            if (s) m_sat[i] = 1'b1;
                        end
                        m_pend[m_t-1] = 1'b0;
                    end
                end else if (m_sync && m_t <= 2*NW) begin
                    for (int i = 0; i < NI; i++) m_wt[i][m_t-NW-1] = m_w[i][m_t-NW-1];
                end
                if (m_t == len - 1) begin m_done = 1'b1; m_cnt = m_sync ? 0 : m_cnt + 1; end
                if (m_t == len) m_busy = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, sampled 2 time units after the clock edge.
    initial forever begin
        @(posedge clk);
        #2;
        for (int i = 0; i < NI; i++) begin
            logic [63:0] ew, et;
            for (int k = 0; k < NW; k++) begin
                ew[16*k +: 16] = m_w[i][k];
                et[16*k +: 16] = m_wt[i][k];
            end
            chk($sformatf("w3_flat[%0d]", i), wf[i], ew);
            chk($sformatf("w3t_flat[%0d]", i), wtf[i], et);
            chk($sformatf("sat_flag[%0d]", i), 64'(sat[i]), 64'(m_sat[i]));
            chk($sformatf("ready[%0d]", i), 64'(rdy[i]), 64'(!m_busy));
            chk($sformatf("done[%0d]", i), 64'(dn[i]), 64'(m_done));
            chk($sformatf("drop_err[%0d]", i), 64'(drp[i]), 64'(m_drop));
            chk($sformatf("upd_cnt[%0d]", i), 64'(uc[i]), 64'(m_cnt));
        end
    end

    task automatic cap(input logic [1:0] idx, input logic [15:0] val);
        in_valid = 1'b1; in_idx = idx; deltaw3 = val;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Command already driven; measures cycles from the command edge to done.
    task automatic wait_done(input int exp_lat, input string nm);
        int n;
        @(negedge clk);
        controller = 4'd0; step = 4'd0; in_valid = 1'b0;
        n = 1;
        while (!dn[0] && n < 40) begin @(negedge clk); n++; end
        chk(nm, 64'(n), 64'(exp_lat));
        @(negedge clk);
    endtask

    task automatic run_cmd(input int exp_lat, input string nm);
        controller = 4'd10; step = 4'd1;
        wait_done(exp_lat, nm);
    endtask

    initial begin
        @(negedge clk); @(negedge clk);
        chk("reset_w3", wf[0], 64'h0400_0400_0400_0400);
        chk("reset_w3t", wtf[0], 64'h0400_0400_0400_0400);
        chk("reset_ready", 64'(rdy[0]), 64'd1);
        rst = 1'b1;
        @(negedge clk);

        cap(2'd0, 16'h0080);
        cap(2'd2, 16'hFF80);
        run_cmd(NW + 1, "lat_basic");
        chk("basic_w3", wf[0], 64'h0400_0480_0400_0380);
        chk("basic_w3t", wtf[0], 64'h0400_0400_0400_0400);
        chk("basic_cnt", 64'(uc[0]), 64'd1);

        cap(2'd1, 16'h0100);
        run_cmd(2*NW + 1, "lat_sync");
        chk("sync_w3", wf[0], 64'h0400_0480_0300_0380);
        chk("sync_w3t", wtf[0], 64'h0400_0480_0300_0380);
        chk("sync_cnt", 64'(uc[0]), 64'd0);

        controller = 4'd10; step = 4'd0;
        @(negedge clk);
        controller = 4'd0;
        repeat (3) begin
            chk("gate_ready", 64'(rdy[0]), 64'd1);
            chk("gate_done", 64'(dn[0]), 64'd0);
            @(negedge clk);
        end

        cap(2'd3, 16'h8000);
        cap(2'd0, 16'h7FFF);
        run_cmd(NW + 1, "lat_sat");
        chk("sat_hi_w3", 64'(wf[1][63:48]), 64'h7FFF);
        chk("sat_hi_flag", 64'(sat[1]), 64'd1);
        chk("sat_lo_w0", 64'(wf[2][15:0]), 64'h8000);
        chk("sat_lo_flag", 64'(sat[2]), 64'd1);
        chk("pre_drop", 64'(drp[0]), 64'd0);

        controller = 4'd10; step = 4'd3;
        @(negedge clk);
        controller = 4'd0; step = 4'd0;
        in_valid = 1'b1; in_idx = 2'd1; deltaw3 = 16'h1234;
        wait_done(2*NW, "lat_drop");
        chk("drop_err", 64'(drp[0]), 64'd1);
        chk("drop_w3", wf[0], 64'h7FFF_0480_0300_8381);

        cap(2'd2, 16'h0010);
        cap(2'd2, 16'h0020);
        in_valid = 1'b1; in_idx = 2'd0; deltaw3 = 16'h0001;
        controller = 4'd10; step = 4'd2;
        wait_done(NW + 1, "lat_same_cycle");
        chk("boundary_w3", wf[0], 64'h7FFF_0460_0300_8380);

        cap(2'd0, 16'h0100);
        cap(2'd1, 16'h0100);
        controller = 4'd10; step = 4'd1;
        @(negedge clk);
        controller = 4'd0; step = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_w3", wf[0], 64'h0400_0400_0400_0400);
        chk("midrst_w3t", wtf[0], 64'h0400_0400_0400_0400);
        chk("midrst_ready", 64'(rdy[0]), 64'd1);
        chk("midrst_flags", {61'd0, dn[0], sat[0], drp[0]}, 64'd0);
        chk("midrst_cnt", 64'(uc[0]), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int c = 0; c < 3000; c++) begin
            int sel;
            rst = ($urandom_range(0, 499) != 0);
            in_valid = ($urandom_range(0, 2) == 0);
            in_idx = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 3);
            deltaw3 = (sel == 0) ? 16'h8000 : (sel == 1) ? 16'h7FFF :
                      (sel == 2) ? 16'($urandom_range(0, 511)) : 16'($urandom);
            controller = ($urandom_range(0, 5) == 0) ? 4'd10 : 4'($urandom_range(0, 15));
            step = 4'($urandom_range(0, 3));
            @(negedge clk);
        end
        rst = 1'b1; in_valid = 1'b0; controller = 4'd0; step = 4'd0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
